// File: rtl/rvh_l1d_fifo_enq_arb_pkg.sv
// Shared types and helpers for the L1D FIFO enqueue arbiter and related pickers.
package rvh_l1d_arb_pkg;

   typedef enum logic [1:0] {
      ARB_RUN,
      ARB_FLUSH,
      ARB_QUIESCE
   } arb_state_e;

   // Grant-index width; a single-requester index still needs one bit.
   function automatic int unsigned arb_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rvh_l1d_fifo_enq_arb_if.sv
// Requester, FIFO-enqueue and flush signals of the arbiter, bundled as one interface.
interface rvh_l1d_fifo_enq_arb_if
   import rvh_l1d_arb_pkg::*;
#(
   parameter int REQ_NUM       = 4,
   parameter int PAYLOAD_WIDTH = 3
);
   localparam int REQ_IDX_W = arb_idx_w(REQ_NUM);

   logic [REQ_NUM-1:0]               req_vld_i;
   logic [REQ_NUM*PAYLOAD_WIDTH-1:0] req_payload_i;
   logic [REQ_NUM-1:0]               req_rdy_o;
   logic                             fifo_enq_vld_o;
   logic [PAYLOAD_WIDTH-1:0]         fifo_enq_payload_o;
   logic                             fifo_enq_rdy_i;
   logic                             fifo_flush_o;
   logic                             flush_req_i;
   logic                             flush_busy_o;
   logic [REQ_IDX_W-1:0]             grant_idx_o;

   // Requesters and the FIFO drive the arbiter through this side.
   modport master (
      output req_vld_i, req_payload_i, fifo_enq_rdy_i, flush_req_i,
      input  req_rdy_o, fifo_enq_vld_o, fifo_enq_payload_o, fifo_flush_o,
             flush_busy_o, grant_idx_o
   );

   modport slave (
      input  req_vld_i, req_payload_i, fifo_enq_rdy_i, flush_req_i,
      output req_rdy_o, fifo_enq_vld_o, fifo_enq_payload_o, fifo_flush_o,
             flush_busy_o, grant_idx_o
   );

endinterface

// File: rtl/rvh_l1d_fifo_enq_arb_picker.sv
// Combinational round-robin first-one search starting at start_i, wrapping modulo N.
module rvh_rr_picker #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  vec_i,
   input  logic [IW-1:0] start_i,
   output logic [N-1:0]  gnt_oh_o,
   output logic [IW-1:0] idx_o,
   output logic          vld_o
);

   logic [IW-1:0] cand_idx [N];

   // cand_idx[k] is the requester examined at search offset k; start_i < N so one subtract wraps.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_cand
         logic [IW:0] sum_w;
         assign sum_w         = {1'b0, start_i} + (IW+1)'(gi);
         assign cand_idx[gi]  = (sum_w >= (IW+1)'(N)) ? IW'(sum_w - (IW+1)'(N)) : IW'(sum_w);
         assign gnt_oh_o[gi]  = vld_o && (idx_o == IW'(gi));
      end
   endgenerate

   always_comb begin
      vld_o = 1'b0;
      idx_o = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (vec_i[cand_idx[k]]) begin
            vld_o = 1'b1;
            idx_o = cand_idx[k];
         end
      end
   end

endmodule

// File: rtl/rvh_l1d_fifo_enq_arb.sv
// Round-robin arbiter with stall lock and flush/quiesce sequencer in front of the L1D FIFO enqueue port.
module rvh_l1d_fifo_enq_arb
   import rvh_l1d_arb_pkg::*;
#(
   parameter int REQ_NUM       = 4,
   parameter int PAYLOAD_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   rvh_l1d_fifo_enq_arb_if.slave arb_if
);
   localparam int REQ_IDX_W = arb_idx_w(REQ_NUM);

   arb_state_e             state_q, state_d;
   logic [REQ_IDX_W-1:0]   rr_ptr_q;
   logic                   lock_vld_q;
   logic [REQ_IDX_W-1:0]   lock_idx_q;

   logic [PAYLOAD_WIDTH-1:0] payload_arr [REQ_NUM];
   logic [REQ_NUM-1:0]       pick_oh;
   logic [REQ_IDX_W-1:0]     pick_idx;
   logic                     pick_vld;
   logic                     lock_hit;
   logic                     grant_vld;
   logic [REQ_IDX_W-1:0]     grant_idx;
   logic                     enq_vld;
   logic                     fire;
   logic                     stall;

   generate
      for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_req
         assign payload_arr[gi]      = arb_if.req_payload_i[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
         assign arb_if.req_rdy_o[gi] = fire && (grant_idx == REQ_IDX_W'(gi));
      end
   endgenerate

   rvh_rr_picker #(
      .N  (REQ_NUM),
      .IW (REQ_IDX_W)
   ) u_picker (
      .vec_i    (arb_if.req_vld_i),
      .start_i  (rr_ptr_q),
      .gnt_oh_o (pick_oh),
      .idx_o    (pick_idx),
      .vld_o    (pick_vld)
   );

   // A stalled grant keeps priority only while its requester still asserts valid.
   assign lock_hit  = lock_vld_q && arb_if.req_vld_i[lock_idx_q];
   assign grant_vld = (state_q == ARB_RUN) && (lock_hit || pick_vld);
   assign grant_idx = !grant_vld ? '0 : (lock_hit ? lock_idx_q : pick_idx);
   assign enq_vld   = grant_vld && !arb_if.flush_req_i;
   assign fire      = enq_vld && arb_if.fifo_enq_rdy_i;
   assign stall     = enq_vld && !arb_if.fifo_enq_rdy_i;

   assign arb_if.fifo_enq_vld_o     = enq_vld;
   assign arb_if.fifo_enq_payload_o = grant_vld ? payload_arr[grant_idx] : '0;
   assign arb_if.grant_idx_o        = grant_idx;
   assign arb_if.fifo_flush_o       = (state_q == ARB_FLUSH);
   assign arb_if.flush_busy_o       = (state_q != ARB_RUN);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_RUN:     if (arb_if.flush_req_i) state_d = ARB_FLUSH;
         ARB_FLUSH:   state_d = ARB_QUIESCE;
         ARB_QUIESCE: state_d = ARB_RUN;
         default:     state_d = ARB_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_RUN;
         rr_ptr_q   <= '0;
         lock_vld_q <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         state_q <= state_d;
         if (fire) begin
            rr_ptr_q   <= (grant_idx == REQ_IDX_W'(REQ_NUM - 1)) ? '0 : grant_idx + 1'b1;
            lock_vld_q <= 1'b0;
         end else if (stall) begin
            lock_vld_q <= 1'b1;
            lock_idx_q <= grant_idx;
         end else if (lock_vld_q && !arb_if.req_vld_i[lock_idx_q]) begin
            lock_vld_q <= 1'b0;
         end
         // Flush entry always wins; enq_vld is already suppressed this cycle.
         if ((state_q == ARB_RUN) && arb_if.flush_req_i) begin
            lock_vld_q <= 1'b0;
         end
      end
   end

   logic unused_pick_oh;
   assign unused_pick_oh = ^pick_oh;

endmodule

// File: tb/tb_rvh_l1d_fifo_enq_arb.sv
// Directed bench: stimulus queues expected enqueues, a monitor checks each fired enqueue.
module tb_rvh_l1d_fifo_enq_arb;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rvh_l1d_fifo_enq_arb_if #(.REQ_NUM(4), .PAYLOAD_WIDTH(3)) bus ();
   rvh_l1d_fifo_enq_arb_if #(.REQ_NUM(3), .PAYLOAD_WIDTH(3)) bus3 ();

   rvh_l1d_fifo_enq_arb #(.REQ_NUM(4), .PAYLOAD_WIDTH(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .arb_if (bus)
   );

   rvh_l1d_fifo_enq_arb #(.REQ_NUM(3), .PAYLOAD_WIDTH(3)) dut3 (
      .clk    (clk),
      .rst    (rst),
      .arb_if (bus3)
   );

   typedef struct packed {
      logic [1:0] idx;
      logic [2:0] pl;
      logic [3:0] rdy;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp     = 0;
   int   n_err     = 0;
   int   flush_cnt = 0;
   bit   hold_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] idx, input logic [2:0] pl, input logic [3:0] rdy);
      exp_t e;
      e.idx = idx;
      e.pl  = pl;
      e.rdy = rdy;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every accepted enqueue must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && bus.fifo_enq_vld_o && bus.fifo_enq_rdy_i) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_enq: got grant %0d payload %0d want no enqueue", bus.grant_idx_o, bus.fifo_enq_payload_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("enq_grant", 32'(bus.grant_idx_o), 32'(e.idx));
            chk("enq_payload", 32'(bus.fifo_enq_payload_o), 32'(e.pl));
            chk("enq_req_rdy", 32'(bus.req_rdy_o), 32'(e.rdy));
            $display("enq: grant %0d payload %0d req_rdy %b", bus.grant_idx_o, bus.fifo_enq_payload_o, bus.req_rdy_o);
         end
      end
      if (bus.fifo_flush_o) flush_cnt++;
   end

   // Requester rule: a pending (valid, not accepted) request stays valid with a stable payload.
   logic [3:0]  prev_pend = '0;
   logic [11:0] prev_pl   = '0;
   always @(negedge clk) begin
      if (rst) begin
         prev_pend <= '0;
      end else begin
         if (hold_en) begin
            for (int i = 0; i < 4; i++) begin
               if (prev_pend[i]) begin
                  n_cmp++;
                  if (!bus.req_vld_i[i] || (bus.req_payload_i[i*3 +: 3] != prev_pl[i*3 +: 3])) begin
                     n_err++;
                     $display("FAIL req_hold[%0d]: got vld %b payload %0d want vld 1 payload %0d", i, bus.req_vld_i[i], bus.req_payload_i[i*3 +: 3], prev_pl[i*3 +: 3]);
                  end
               end
            end
         end
         prev_pend <= bus.req_vld_i & ~bus.req_rdy_o;
         prev_pl   <= bus.req_payload_i;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst                 = 1'b1;
      bus.req_vld_i       = '0;
      bus.req_payload_i   = '0;
      bus.fifo_enq_rdy_i  = 1'b0;
      bus.flush_req_i     = 1'b0;
      bus3.req_vld_i      = '0;
      bus3.req_payload_i  = '0;
      bus3.fifo_enq_rdy_i = 1'b0;
      bus3.flush_req_i    = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_enq_vld", 32'(bus.fifo_enq_vld_o), 0);
      chk("rst_req_rdy", 32'(bus.req_rdy_o), 0);
      chk("rst_flush", 32'(bus.fifo_flush_o), 0);
      chk("rst_busy", 32'(bus.flush_busy_o), 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("idle_enq_vld", 32'(bus.fifo_enq_vld_o), 0);
      chk("idle_payload", 32'(bus.fifo_enq_payload_o), 0);

      // Rotation: all valid, FIFO ready -> 0,1,2,3,0
      bus.req_payload_i = {3'd3, 3'd2, 3'd1, 3'd0};
      push(0, 0, 4'b0001); push(1, 1, 4'b0010); push(2, 2, 4'b0100);
      push(3, 3, 4'b1000); push(0, 0, 4'b0001);
      tick();
      hold_en = 1'b1;
      bus.req_vld_i = 4'b1111;
      bus.fifo_enq_rdy_i = 1'b1;
      repeat (5) tick();
      hold_en = 1'b0;
      bus.req_vld_i = '0;
      bus.req_payload_i = {3'd6, 3'd5, 3'd7, 3'd3};
      tick();
      hold_en = 1'b1;

      // Stall lock on requester 2 (rr_ptr=1); 1 and 3 join while stalled
      push(2, 5, 4'b0100); push(3, 6, 4'b1000); push(1, 7, 4'b0010);
      bus.req_vld_i = 4'b0100;
      bus.fifo_enq_rdy_i = 1'b0;
      @(negedge clk);
      chk("stall0_grant", 32'(bus.grant_idx_o), 2);
      chk("stall0_vld", 32'(bus.fifo_enq_vld_o), 1);
      chk("stall0_req_rdy", 32'(bus.req_rdy_o), 0);
      for (int c = 1; c < 3; c++) begin
         tick();
         bus.req_vld_i = 4'b1110;
         @(negedge clk);
         chk("stall_grant", 32'(bus.grant_idx_o), 2);
         chk("stall_payload", 32'(bus.fifo_enq_payload_o), 5);
         chk("stall_req_rdy", 32'(bus.req_rdy_o), 0);
      end
      tick();
      bus.fifo_enq_rdy_i = 1'b1;
      @(negedge clk);
      chk("unstall_req_rdy", 32'(bus.req_rdy_o), 32'b0100);
      tick();
      bus.req_vld_i = 4'b1010;
      @(negedge clk);
      chk("after_lock_grant", 32'(bus.grant_idx_o), 3);
      tick();
      bus.req_vld_i = 4'b0010;
      tick();
      bus.req_vld_i = '0;

      // Sparse wrap (rr_ptr=2 -> 3 -> only req 1 -> rr_ptr=2)
      push(2, 5, 4'b0100); push(1, 7, 4'b0010); push(0, 3, 4'b0001); push(1, 7, 4'b0010);
      bus.req_vld_i = 4'b0100;
      tick();
      bus.req_vld_i = 4'b0010;
      @(negedge clk);
      chk("sparse_grant", 32'(bus.grant_idx_o), 1);
      tick();
      bus.req_vld_i = 4'b0011;
      @(negedge clk);
      chk("sparse_ptr_grant", 32'(bus.grant_idx_o), 0);
      tick();
      bus.req_vld_i = 4'b0010;
      tick();
      bus.req_vld_i = '0;

      // Flush with req 0 locked, plus an ignored flush request during QUIESCE
      push(0, 3, 4'b0001);
      bus.req_vld_i = 4'b0001;
      bus.fifo_enq_rdy_i = 1'b0;
      @(negedge clk);
      chk("pre_flush_grant", 32'(bus.grant_idx_o), 0);
      tick();
      bus.flush_req_i = 1'b1;
      @(negedge clk);
      chk("flush_req_enq_vld", 32'(bus.fifo_enq_vld_o), 0);
      chk("flush_req_flush", 32'(bus.fifo_flush_o), 0);
      tick();
      bus.flush_req_i = 1'b0;
      @(negedge clk);
      chk("flush_flush", 32'(bus.fifo_flush_o), 1);
      chk("flush_busy", 32'(bus.flush_busy_o), 1);
      chk("flush_enq_vld", 32'(bus.fifo_enq_vld_o), 0);
      tick();
      bus.flush_req_i = 1'b1;
      bus.fifo_enq_rdy_i = 1'b1;
      @(negedge clk);
      chk("quiesce_flush", 32'(bus.fifo_flush_o), 0);
      chk("quiesce_busy", 32'(bus.flush_busy_o), 1);
      chk("quiesce_enq_vld", 32'(bus.fifo_enq_vld_o), 0);
      tick();
      bus.flush_req_i = 1'b0;
      @(negedge clk);
      chk("post_flush_busy", 32'(bus.flush_busy_o), 0);
      chk("post_flush_flush", 32'(bus.fifo_flush_o), 0);
      chk("post_flush_enq_vld", 32'(bus.fifo_enq_vld_o), 1);
      tick();
      bus.req_vld_i = '0;

      // Reset while in FLUSH (rr_ptr=1 beforehand)
      bus.flush_req_i = 1'b1;
      tick();
      bus.flush_req_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rstflush_flush", 32'(bus.fifo_flush_o), 1);
      tick();
      rst = 1'b0;
      push(0, 3, 4'b0001);
      bus.req_vld_i = 4'b1111;
      @(negedge clk);
      chk("rstflush_flush_after", 32'(bus.fifo_flush_o), 0);
      chk("rstflush_busy_after", 32'(bus.flush_busy_o), 0);
      chk("rstflush_grant", 32'(bus.grant_idx_o), 0);
      tick();
      hold_en = 1'b0;
      bus.req_vld_i = '0;
      tick();

      // Locked requester drops valid; another is arbitrated the same cycle (rr_ptr=1)
      push(3, 6, 4'b1000);
      bus.req_vld_i = 4'b0010;
      bus.fifo_enq_rdy_i = 1'b0;
      @(negedge clk);
      chk("droplock_grant0", 32'(bus.grant_idx_o), 1);
      tick();
      bus.req_vld_i = 4'b1000;
      bus.fifo_enq_rdy_i = 1'b1;
      @(negedge clk);
      chk("droplock_grant1", 32'(bus.grant_idx_o), 3);
      tick();
      bus.req_vld_i = '0;
      tick();
      hold_en = 1'b1;

      // Three-requester instance: pointer wraps 2 -> 0
      bus3.req_payload_i = {3'd3, 3'd2, 3'd1};
      bus3.req_vld_i = 3'b111;
      bus3.fifo_enq_rdy_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("n3_grant", 32'(bus3.grant_idx_o), 32'(c % 3));
         chk("n3_payload", 32'(bus3.fifo_enq_payload_o), 32'((c % 3) + 1));
         chk("n3_req_rdy", 32'(bus3.req_rdy_o), 32'(1 << (c % 3)));
         $display("enq3: grant %0d payload %0d req_rdy %b", bus3.grant_idx_o, bus3.fifo_enq_payload_o, bus3.req_rdy_o);
         tick();
      end
      bus3.req_vld_i = '0;

      repeat (2) tick();
      chk("exp_queue_drained", 32'(exp_q.size()), 0);
      chk("flush_pulse_count", 32'(flush_cnt), 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
